// File: rtl/cdr_phase_ctrl.sv
// -----------------------------------------------------------------------------
// cdr_phase_ctrl
//
// Digital loop filter and phase-select controller for the Turbo XAUI CDR.
// Each vote window the upstream majority-vote logic delivers early/late vote
// counts. Their difference is integrated into a saturating signed
// accumulator. When the integral crosses +/-THRESH the wrap-around phase
// pointer steps one position. After a step, the next SETTLE_WIN windows are
// discarded, because they were measured against the old phase. A run of
// LOCK_WIN quiet windows (|ea-la| <= 1) raises the lock indicator. Only a step
// or reset clears it.
//
// Optional feature: define CDR_PHASE_FREEZE_EN to add the freeze input.
// While freeze is high, vote strobes are discarded and all state is held.
//
// Ports:
//   clk         controller clock (recovered-clock domain)
//   rst         asynchronous, active-high reset
//   vote_valid  one-cycle strobe: ea/la hold a new window result
//   ea          early vote count for the window (0..3)
//   la          late vote count for the window (0..3)
//   freeze      (CDR_PHASE_FREEZE_EN only) discard strobes while high
//   phase_sel   registered phase pointer to the interpolator mux
//   up          one-cycle pulse: phase_sel incremented
//   dn          one-cycle pulse: phase_sel decremented
//   locked      lock indicator
// -----------------------------------------------------------------------------
module cdr_phase_ctrl #(
    parameter int PHASE_W    = 3,
    parameter int ACC_W      = 5,
    parameter int THRESH     = 4,
    parameter int SETTLE_WIN = 3,
    parameter int LOCK_WIN   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vote_valid,
    input  logic [1:0]         ea,
    input  logic [1:0]         la,
`ifdef CDR_PHASE_FREEZE_EN
    input  logic               freeze,
`endif
    output logic [PHASE_W-1:0] phase_sel,
    output logic               up,
    output logic               dn,
    output logic               locked
);

    localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
    localparam int LCW     = (LOCK_WIN > 0)   ? $clog2(LOCK_WIN + 1)   : 1;
    localparam int SCW     = (SETTLE_WIN > 0) ? $clog2(SETTLE_WIN + 1) : 1;

    // The sum is held one bit wider than the accumulator. This lets it be
    // compared against the saturation and step limits without overflow.
    localparam logic signed [ACC_W:0]   SAT_HI = (ACC_W + 1)'(ACC_MAX);
    localparam logic signed [ACC_W:0]   SAT_LO = -SAT_HI;
    localparam logic signed [ACC_W:0]   THR_HI = (ACC_W + 1)'(THRESH);
    localparam logic signed [ACC_W:0]   THR_LO = -THR_HI;
    localparam logic signed [ACC_W-1:0] D_ONE  = ACC_W'(1);
    localparam logic [LCW-1:0]          LOCK_MAX    = LCW'(LOCK_WIN);
    localparam logic [SCW-1:0]          SETTLE_LOAD = SCW'(SETTLE_WIN);

    typedef enum logic {
        TRACK,
        SETTLE
    } state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [SCW-1:0]          settle_cnt;
    logic [LCW-1:0]          lock_cnt;

    logic                    accept;
    logic signed [ACC_W-1:0] diff;
    logic signed [ACC_W:0]   sum_w;
    logic signed [ACC_W:0]   nxt;
    logic                    quiet;
    logic [LCW-1:0]          lock_nxt;
    logic                    step_up;
    logic                    step_dn;

    // Strobe qualification: a frozen strobe is treated as if it never came.
`ifdef CDR_PHASE_FREEZE_EN
    assign accept = vote_valid & ~freeze;
`else
    assign accept = vote_valid;
`endif

    // NOTE: every signal in this block gets a default before any branch.
    // A path that leaves an output unassigned would infer a latch.
    always_comb begin
        diff     = '0;
        sum_w    = '0;
        nxt      = '0;
        quiet    = 1'b0;
        lock_nxt = '0;
        step_up  = 1'b0;
        step_dn  = 1'b0;

        // ea/la are unsigned counts. Zero-extend them before the signed subtract.
        diff  = $signed(ACC_W'(ea)) - $signed(ACC_W'(la));
        sum_w = (ACC_W + 1)'(acc) + (ACC_W + 1)'(diff);

        if (sum_w > SAT_HI) begin
            nxt = SAT_HI;
        end else if (sum_w < SAT_LO) begin
            nxt = SAT_LO;
        end else begin
            nxt = sum_w;
        end

        step_up = (nxt >= THR_HI);
        step_dn = (nxt <= THR_LO);

        quiet = (diff <= D_ONE) && (diff >= -D_ONE);
        if (!quiet) begin
            lock_nxt = '0;
        end else if (lock_cnt == LOCK_MAX) begin
            lock_nxt = lock_cnt;
        end else begin
            lock_nxt = lock_cnt + LCW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments only. All of them
    // then see the same pre-edge values, whatever order they are written in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= TRACK;
            acc        <= '0;
            settle_cnt <= '0;
            lock_cnt   <= '0;
            phase_sel  <= '0;
            up         <= 1'b0;
            dn         <= 1'b0;
            locked     <= 1'b0;
        end else begin
            // Step pulses last exactly one cycle unless re-armed below.
            up <= 1'b0;
            dn <= 1'b0;

            if (accept) begin
                case (state)
                    TRACK: begin
                        if (step_up || step_dn) begin
                            phase_sel <= step_up ? phase_sel + PHASE_W'(1)
                                                 : phase_sel - PHASE_W'(1);
                            up        <= step_up;
                            dn        <= step_dn;
                            acc       <= '0;
                            lock_cnt  <= '0;
                            locked    <= 1'b0;
                            if (SETTLE_WIN != 0) begin
                                state      <= SETTLE;
                                settle_cnt <= SETTLE_LOAD;
                            end
                        end else begin
                            acc      <= nxt[ACC_W-1:0];
                            lock_cnt <= lock_nxt;
                            if (lock_nxt == LOCK_MAX) begin
                                locked <= 1'b1;
                            end
                        end
                    end

                    SETTLE: begin
                        // Votes from the old phase are dropped. acc and
                        // lock_cnt are left as they are.
                        settle_cnt <= settle_cnt - SCW'(1);
                        if (settle_cnt <= SCW'(1)) begin
                            state <= TRACK;
                        end
                    end

                    default: state <= TRACK;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cdr_phase_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cdr_phase_ctrl
//
// Two controllers are driven by the same vote stream. dut_a uses the default
// parameters. dut_b uses THRESH=15 with no settle blanking, so the integrator
// runs right up to the saturation limit. Each driven cycle is passed through
// an integer reference model of the loop, and the expected outputs are
// queued. A monitor pops one entry per clock and compares.
// -----------------------------------------------------------------------------
module tb_cdr_phase_ctrl;

    localparam int PHASE_W   = 3;
    localparam int ACC_W     = 5;
    localparam int NPH       = 1 << PHASE_W;
    localparam int ACC_MAX   = (1 << (ACC_W - 1)) - 1;
    localparam int LOCK_WIN  = 8;
    localparam int THRESH_A  = 4;
    localparam int SETTLE_A  = 3;
    localparam int THRESH_B  = 15;
    localparam int SETTLE_B  = 0;
`ifdef CDR_PHASE_FREEZE_EN
    localparam bit HAS_FREEZE = 1'b1;
`else
    localparam bit HAS_FREEZE = 1'b0;
`endif

    typedef struct {
        int acc;
        int phase;
        int settle_left;
        int quiet_run;
        bit locked;
    } mstate_t;

    typedef struct packed {
        logic [PHASE_W-1:0] phase;
        logic               up;
        logic               dn;
        logic               locked;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               vote_valid;
    logic [1:0]         ea;
    logic [1:0]         la;
`ifdef CDR_PHASE_FREEZE_EN
    logic               freeze;
`endif
    logic [PHASE_W-1:0] phase_a, phase_b;
    logic               up_a, dn_a, locked_a;
    logic               up_b, dn_b, locked_b;

    int checks = 0;
    int errors = 0;

    exp_t    q_a[$];
    exp_t    q_b[$];
    mstate_t st_a;
    mstate_t st_b;

    always #5 clk = ~clk;

    cdr_phase_ctrl #(
        .PHASE_W(PHASE_W), .ACC_W(ACC_W), .THRESH(THRESH_A),
        .SETTLE_WIN(SETTLE_A), .LOCK_WIN(LOCK_WIN)
    ) dut_a (
        .clk(clk), .rst(rst), .vote_valid(vote_valid), .ea(ea), .la(la),
`ifdef CDR_PHASE_FREEZE_EN
        .freeze(freeze),
`endif
        .phase_sel(phase_a), .up(up_a), .dn(dn_a), .locked(locked_a)
    );

    cdr_phase_ctrl #(
        .PHASE_W(PHASE_W), .ACC_W(ACC_W), .THRESH(THRESH_B),
        .SETTLE_WIN(SETTLE_B), .LOCK_WIN(LOCK_WIN)
    ) dut_b (
        .clk(clk), .rst(rst), .vote_valid(vote_valid), .ea(ea), .la(la),
`ifdef CDR_PHASE_FREEZE_EN
        .freeze(freeze),
`endif
        .phase_sel(phase_b), .up(up_b), .dn(dn_b), .locked(locked_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic mstate_t model_reset();
        mstate_t s;
        s.acc = 0; s.phase = 0; s.settle_left = 0; s.quiet_run = 0; s.locked = 1'b0;
        return s;
    endfunction

    // Loop behaviour as arithmetic on integers. After each step, a count of
    // windows still to be ignored stands in for the settle period.
    function automatic exp_t model_step(inout mstate_t s, input bit take, input int e,
                                        input int l, input int thresh, input int settle_win);
        exp_t r;
        int d;
        int n;
        r.up = 1'b0;
        r.dn = 1'b0;
        if (take) begin
            if (s.settle_left > 0) begin
                s.settle_left--;
            end else begin
                d = e - l;
                n = s.acc + d;
                if (n > ACC_MAX)  n = ACC_MAX;
                if (n < -ACC_MAX) n = -ACC_MAX;
                if (n >= thresh || n <= -thresh) begin
                    r.up          = (n > 0);
                    r.dn          = (n < 0);
                    s.phase       = (s.phase + ((n > 0) ? 1 : -1) + NPH) % NPH;
                    s.acc         = 0;
                    s.quiet_run   = 0;
                    s.locked      = 1'b0;
                    s.settle_left = settle_win;
                end else begin
                    s.acc = n;
                    if (d >= -1 && d <= 1) begin
                        if (s.quiet_run < LOCK_WIN) s.quiet_run++;
                    end else begin
                        s.quiet_run = 0;
                    end
                    if (s.quiet_run == LOCK_WIN) s.locked = 1'b1;
                end
            end
        end
        r.phase  = PHASE_W'(s.phase);
        r.locked = s.locked;
        return r;
    endfunction

    // Drive one cycle of stimulus on the falling edge and queue what both
    // controllers should show after the following rising edge.
    task automatic cycle(input bit v, input int e, input int l, input bit frz);
        bit take;
        @(negedge clk);
        vote_valid = v;
        ea         = e[1:0];
        la         = l[1:0];
`ifdef CDR_PHASE_FREEZE_EN
        freeze     = frz;
`endif
        take = v && !(frz && HAS_FREEZE);
        q_a.push_back(model_step(st_a, take, e, l, THRESH_A, SETTLE_A));
        q_b.push_back(model_step(st_b, take, e, l, THRESH_B, SETTLE_B));
    endtask

    task automatic strobe(input int e, input int l, input int times);
        for (int i = 0; i < times; i++) begin
            cycle(1'b1, e, l, 1'b0);
        end
    endtask

    // Let the monitor consume everything queued so far.
    task automatic drain();
        cycle(1'b0, 0, 0, 1'b0);
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " phase_a"}, 32'(phase_a), 32'd0);
        check({tag, " up/dn/locked a"}, 32'({up_a, dn_a, locked_a}), 32'd0);
        check({tag, " phase_b"}, 32'(phase_b), 32'd0);
        check({tag, " up/dn/locked b"}, 32'({up_b, dn_b, locked_b}), 32'd0);
    endtask

    always @(posedge clk) begin
        exp_t ex;
        #1;
        if (q_a.size() > 0) begin
            ex = q_a.pop_front();
            check("dut_a {phase,up,dn,locked}", 32'({phase_a, up_a, dn_a, locked_a}), 32'(ex));
        end
        if (q_b.size() > 0) begin
            ex = q_b.pop_front();
            check("dut_b {phase,up,dn,locked}", 32'({phase_b, up_b, dn_b, locked_b}), 32'(ex));
        end
    end

    initial begin
        int mode;
        int e;
        int l;
        bit v;
        bit frz;

        rst        = 1'b1;
        vote_valid = 1'b0;
        ea         = '0;
        la         = '0;
`ifdef CDR_PHASE_FREEZE_EN
        freeze     = 1'b0;
`endif
        st_a = model_reset();
        st_b = model_reset();
        #1;
        check_reset_outputs("power-on reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Up step, settle blanking, then a second up step.
        strobe(3, 0, 2);
        strobe(3, 0, 3);
        strobe(3, 0, 2);
        drain();
        check("phase_a after two up steps", 32'(phase_a), 32'd2);

        // Reset asserted mid-cycle clears outputs without waiting for an edge.
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid-cycle reset");
        st_a = model_reset();
        st_b = model_reset();
        @(negedge clk);
        rst = 1'b0;
        strobe(1, 0, 1);

        // Wrap: eight down steps back to 0, then 0 -> 7 and up 7 -> 0.
        for (int i = 0; i < 9; i++) begin
            strobe(0, 3, 2);
            strobe(0, 0, SETTLE_A);
        end
        strobe(3, 0, 2);
        strobe(0, 0, SETTLE_A);
        drain();
        check("phase_a after wrap up from 7", 32'(phase_a), 32'd0);

        // Lock after eight quiet windows, then lost on a step.
        strobe(2, 2, LOCK_WIN);
        drain();
        check("locked_a after quiet run", 32'(locked_a), 32'd1);
        strobe(3, 0, 2);
        strobe(0, 0, SETTLE_A);

        // Cancellation, then integrate up to the saturation limit on dut_b.
        for (int i = 0; i < 6; i++) begin
            strobe(3, 0, 1);
            strobe(0, 3, 1);
        end
        strobe(3, 0, 5);
        strobe(0, 3, 5);
        strobe(0, 0, SETTLE_A);

`ifdef CDR_PHASE_FREEZE_EN
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 3, 0, 1'b1);
        end
        strobe(3, 0, 2);
`endif

        // Randomised windows in blocks, each biased toward one behaviour.
        for (int blk = 0; blk < 40; blk++) begin
            mode = int'($urandom_range(0, 3));
            for (int i = 0; i < 20; i++) begin
                v = ($urandom_range(0, 9) < 7);
                e = int'($urandom_range(0, 3));
                case (mode)
                    0: l = int'($urandom_range(0, 3));
                    1: l = e;
                    2: l = (e > 1) ? int'($urandom_range(0, 1)) : 0;
                    default: begin
                        l = int'($urandom_range(2, 3));
                        e = int'($urandom_range(0, 1));
                    end
                endcase
                frz = HAS_FREEZE && ($urandom_range(0, 9) == 0);
                cycle(v, e, l, frz);
            end
        end

        drain();
        check("scoreboard drained", 32'(q_a.size() + q_b.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdr_phase_ctrl.md
Name: cdr_phase_ctrl

Overview:
- Digital loop filter and phase-select controller for the Turbo XAUI CDR. It consumes the per-window early/late vote counts produced by the majority-vote logic.
- Integrates the vote difference and steps a wrap-around phase pointer to the phase-interpolator mux when the integral crosses a threshold.
- Blanks stale votes after each step and reports lock.
- Runs on the recovered-clock-domain clk. vote_valid is a one-cycle strobe generated upstream on each window-clock rising edge.

Parameters:
- PHASE_W, 3, phase pointer width (2^PHASE_W phases).
- ACC_W, 5, signed integrator width; range -(2^(ACC_W-1)-1)..+(2^(ACC_W-1)-1).
- THRESH, 4, step threshold magnitude; legal range 1..2^(ACC_W-1)-1.
- SETTLE_WIN, 3, vote windows ignored after a phase step; 0 = no blanking.
- LOCK_WIN, 8, consecutive quiet windows required to assert locked.

Ports:
- clk  input  1  controller clock.
- rst  input  1  reset, asynchronous, active-high.
- vote_valid  input  1  one-cycle strobe: ea/la hold a new window result.
- ea  input  2  early vote count for the window (0..3).
- la  input  2  late vote count for the window (0..3).
- phase_sel  output  PHASE_W  registered phase pointer to the interpolator.
- up  output  1  one-cycle pulse: phase_sel incremented.
- dn  output  1  one-cycle pulse: phase_sel decremented.
- locked  output  1  lock indicator.

Behaviour:
- Reset (async, rst=1): phase_sel=0, up=0, dn=0, locked=0, acc=0, settle_cnt=0, lock_cnt=0, state=TRACK.
- Inputs are sampled only on a clk edge with vote_valid=1. vote_valid may be asserted back-to-back.
- diff = ea - la, signed, range -3..+3, computed at ACC_W bits.
- TRACK, on vote_valid:
  - nxt = acc + diff, saturated to ±(2^(ACC_W-1)-1).
  - If nxt >= THRESH: phase_sel += 1 (mod 2^PHASE_W), up=1 for one cycle, acc=0, locked=0, lock_cnt=0. Go to SETTLE with settle_cnt=SETTLE_WIN, or stay in TRACK if SETTLE_WIN=0.
  - Else if nxt <= -THRESH: phase_sel -= 1 (mod 2^PHASE_W), dn=1 for one cycle, acc=0, locked=0, lock_cnt=0, same SETTLE entry rule.
  - Else: acc = nxt. If |diff| <= 1, lock_cnt = min(lock_cnt+1, LOCK_WIN); otherwise lock_cnt = 0. locked is set in the cycle lock_cnt reaches LOCK_WIN. locked is cleared only by a step or reset.
- SETTLE, on vote_valid:
  - Votes are discarded; acc and lock_cnt are unchanged.
  - settle_cnt decrements; when it reaches 0, return to TRACK. Exactly SETTLE_WIN strobes are discarded.
- Latency: phase_sel, up/dn, acc and locked update on the clk edge that samples vote_valid, and are visible the next cycle.
- up and dn are never asserted together. With vote_valid=0, up=dn=0.
- Wrap-around: up from 2^PHASE_W-1 gives 0; dn from 0 gives 2^PHASE_W-1. No error is flagged.
- ea==la gives diff=0, acc is unchanged, and the window counts as quiet.
- rst asserted in any state returns all state to reset values immediately; a pending SETTLE is abandoned.

Optional Feature:
- Macro CDR_PHASE_FREEZE_EN.
- Defined: adds input port freeze (1 bit, after la). While freeze=1, vote_valid strobes are discarded entirely: acc, phase_sel, settle_cnt, lock_cnt and locked are held, and up=dn=0. Strobes resume normal handling the cycle freeze returns to 0.
- Undefined: no freeze port; every strobe is processed as above.

Test Plan:
- Reset: assert rst mid-cycle -> phase_sel=0, up=dn=0, locked=0 immediately; first strobe with ea=1, la=0 gives acc=1 and no step.
- Up step plus settle: strobes (ea=3, la=0) x2 -> after 2nd strobe phase_sel=1, up high exactly 1 cycle, acc=0; next 3 strobes (ea=3, la=0) are ignored; 4th and 5th strobes step again to phase_sel=2.
- Wrap: 8 down-step sequences (ea=0, la=3) from reset -> phase_sel goes 7,6,...,0, one dn pulse per step; up from 7 gives 0.
- Lock: 8 strobes with ea=la=2 -> locked=1 after the 8th strobe, 0 before. A further strobe pair (ea=3, la=0) x2 -> step, locked=0.
- Saturation and cancellation: THRESH=15, ACC_W=5, alternating (3,0)/(0,3) strobes -> acc oscillates 3/0, no step; 5 strobes of (3,0) -> 5th gives acc=15, step up, acc=0.
- Freeze (macro defined): freeze=1 with 10 strobes of (3,0) -> phase_sel, acc, up and dn unchanged; release freeze, 2 strobes -> step up.
